// File: rtl/branch_tag_ctrl_if.sv
// Dispatch / resolve / release bundle between the branch-tag controller and the back end.
// Latency: none (wires only); timing is defined by the controller.
// Backpressure: allocGrant and stall gate dispatch; resolves and releases are never back-pressured.
interface branch_tag_ctrl_if #(
    parameter int BRANCH_NUM = 4
);
    localparam int IDX_W = (BRANCH_NUM > 1) ? $clog2(BRANCH_NUM) : 1;

    // dispatcher side
    logic                  allocReq;
    logic                  allocGrant;
    logic [IDX_W-1:0]      allocNum;
    logic [BRANCH_NUM-1:0] curBranchTag;

    // resolve port A (ALU)
    logic                  resEnA;
    logic [IDX_W-1:0]      resNumA;
    logic                  resMissA;

    // resolve port B (second branch unit)
    logic                  resEnB;
    logic [IDX_W-1:0]      resNumB;
    logic                  resMissB;

    // broadcasts to ROB / reservation stations
    logic                  bFreeEn;
    logic [IDX_W-1:0]      bFreeNum;
    logic                  flushEn;
    logic [BRANCH_NUM-1:0] flushMask;
    logic                  stall;

    modport master (
        output allocReq, resEnA, resNumA, resMissA, resEnB, resNumB, resMissB,
        input  allocGrant, allocNum, curBranchTag, bFreeEn, bFreeNum,
               flushEn, flushMask, stall
    );

    modport slave (
        input  allocReq, resEnA, resNumA, resMissA, resEnB, resNumB, resMissB,
        output allocGrant, allocNum, curBranchTag, bFreeEn, bFreeNum,
               flushEn, flushMask, stall
    );
endinterface

// File: rtl/branch_tag_ctrl.sv
// One-hot branch tag allocator with dual resolve ports, serialised release broadcast and kill/stall on mispredict.
// Latency: grant combinational; release and flush pulses one cycle after the resolve; stall FLUSH_CYCLES cycles.
// Backpressure: allocGrant drops when full, stalled or in reset; surplus correct resolves queue in pend.
module branch_tag_ctrl #(
    parameter int BRANCH_NUM   = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    branch_tag_ctrl_if.slave bus
);
    localparam int IDX_W = (BRANCH_NUM > 1) ? $clog2(BRANCH_NUM) : 1;
    // counter only ever holds FLUSH_CYCLES-1 down to 0
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef logic [BRANCH_NUM-1:0] mask_t;
    typedef logic [IDX_W-1:0]      idx_t;
    typedef enum logic {S_RUN, S_FLUSH} state_t;

    // per-slot state
    mask_t     busy;
    mask_t     pend;
    mask_t     dep [BRANCH_NUM];

    // registered broadcasts
    logic      free_en_q;
    idx_t      free_num_q;
    logic      flush_en_q;
    mask_t     flush_mask_q;

    // stall FSM
    state_t    state, state_nxt;
    logic [FC_W-1:0] fc, fc_nxt;

    // combinational working set
    mask_t     dying;
    mask_t     live;
    logic      any_free;
    logic      grant;
    idx_t      alloc_idx;
    logic      va, vb, ma, mb, miss_any;
    idx_t      miss_idx;
    mask_t     kill;
    mask_t     corr;
    mask_t     cand;
    logic      rel_any;
    idx_t      rel_idx;
    mask_t     busy_nxt;
    mask_t     pend_nxt;
    mask_t     dep_nxt [BRANCH_NUM];

    function automatic mask_t onehot(input idx_t n);
        mask_t m;
        m    = '0;
        m[n] = 1'b1;
        return m;
    endfunction

    // Slots whose release or kill is being broadcast this cycle stay busy until the pulse ends,
    // so the ROB never sees a tag freed and re-granted in the same cycle; they are no longer live.
    always_comb begin
        dying     = '0;
        if (flush_en_q) dying = dying | flush_mask_q;
        if (free_en_q)  dying = dying | onehot(free_num_q);
        live      = busy & ~dying;
        any_free  = ~&busy;
        alloc_idx = '0;
        for (int i = BRANCH_NUM - 1; i >= 0; i--) begin
            if (!busy[i]) alloc_idx = idx_t'(i);
        end
        grant     = bus.allocReq & rst & (state == S_RUN) & any_free;
    end

    // Qualify resolves, pick the oldest mispredict, build the kill set and choose this cycle's release.
    always_comb begin
        va       = bus.resEnA & live[bus.resNumA];
        vb       = bus.resEnB & live[bus.resNumB]
                   & ~(bus.resEnA & (bus.resNumA == bus.resNumB));
        ma       = va & bus.resMissA;
        mb       = vb & bus.resMissB;
        miss_any = ma | mb;

        // A is older than B exactly when B was allocated while A was outstanding
        miss_idx = bus.resNumB;
        if (ma && (!mb || dep[bus.resNumB][bus.resNumA])) miss_idx = bus.resNumA;

        kill = '0;
        if (miss_any) begin
            for (int j = 0; j < BRANCH_NUM; j++) begin
                kill[j] = live[j] & dep[j][miss_idx];
            end
            kill[miss_idx] = 1'b1;
            // a slot granted right now sits behind the mispredicted branch
            if (grant) kill[alloc_idx] = 1'b1;
        end

        corr = '0;
        if (va && !bus.resMissA) corr = corr | onehot(bus.resNumA);
        if (vb && !bus.resMissB) corr = corr | onehot(bus.resNumB);

        cand    = (pend | corr) & ~kill;
        rel_any = |cand;
        rel_idx = '0;
        for (int i = BRANCH_NUM - 1; i >= 0; i--) begin
            if (cand[i]) rel_idx = idx_t'(i);
        end
    end

    // Next slot state: retire pulsed slots, add the granted slot with its snapshot of older branches.
    always_comb begin
        busy_nxt = busy & ~dying;
        if (grant) busy_nxt = busy_nxt | onehot(alloc_idx);

        pend_nxt = cand;
        if (rel_any) pend_nxt = pend_nxt & ~onehot(rel_idx);

        for (int j = 0; j < BRANCH_NUM; j++) begin
            dep_nxt[j] = dying[j] ? '0 : (dep[j] & ~dying);
        end
        if (grant) dep_nxt[alloc_idx] = busy & ~dying;
    end

    // Stall FSM next state: any mispredict (re)starts the recovery window.
    always_comb begin
        state_nxt = state;
        fc_nxt    = fc;
        case (state)
            S_RUN: begin
                if (miss_any) begin
                    state_nxt = S_FLUSH;
                    fc_nxt    = FC_W'(FLUSH_CYCLES - 1);
                end
            end
            S_FLUSH: begin
                if (miss_any) begin
                    fc_nxt    = FC_W'(FLUSH_CYCLES - 1);
                end else if (fc == '0) begin
                    state_nxt = S_RUN;
                end else begin
                    fc_nxt    = fc - 1'b1;
                end
            end
            default: begin
                state_nxt = S_RUN;
                fc_nxt    = '0;
            end
        endcase
    end

    // Slot state and broadcast registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy         <= '0;
            pend         <= '0;
            for (int j = 0; j < BRANCH_NUM; j++) dep[j] <= '0;
            free_en_q    <= 1'b0;
            free_num_q   <= '0;
            flush_en_q   <= 1'b0;
            flush_mask_q <= '0;
        end else begin
            busy         <= busy_nxt;
            pend         <= pend_nxt;
            for (int j = 0; j < BRANCH_NUM; j++) dep[j] <= dep_nxt[j];
            free_en_q    <= rel_any;
            free_num_q   <= rel_idx;
            flush_en_q   <= miss_any;
            flush_mask_q <= kill;
        end
    end

    // Stall FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RUN;
            fc    <= '0;
        end else begin
            state <= state_nxt;
            fc    <= fc_nxt;
        end
    end

    assign bus.allocGrant   = grant;
    assign bus.allocNum     = rst ? alloc_idx : '0;
    assign bus.curBranchTag = busy;
    assign bus.bFreeEn      = free_en_q;
    assign bus.bFreeNum     = free_num_q;
    assign bus.flushEn      = flush_en_q;
    assign bus.flushMask    = flush_mask_q;
    assign bus.stall        = (state == S_FLUSH);
endmodule

// File: tb/tb_branch_tag_ctrl.sv
// Bench for branch_tag_ctrl: directed test-plan scenarios followed by random traffic,
// every cycle compared against an age-ordered reference model of the tag pool.
module tb_branch_tag_ctrl;
    logic clk;
    logic rst;

    branch_tag_ctrl_if #(.BRANCH_NUM(4)) bus ();

    branch_tag_ctrl #(.BRANCH_NUM(4), .FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: slots ordered by allocation sequence number instead of a dependency matrix
    bit       m_busy  [4];
    bit       m_pend  [4];
    bit       m_dying [4];
    int       m_stamp [4];
    int       seq;
    bit       e_free_en;
    int       e_free_num;
    bit       e_flush_en;
    bit [3:0] e_flush_mask;
    int       stall_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_busy[i] = 0; m_pend[i] = 0; m_dying[i] = 0; m_stamp[i] = 0;
        end
        seq = 0; e_free_en = 0; e_free_num = 0; e_flush_en = 0; e_flush_mask = '0; stall_left = 0;
    endtask

    task automatic drive_idle();
        bus.allocReq = 0;
        bus.resEnA = 0; bus.resNumA = '0; bus.resMissA = 0;
        bus.resEnB = 0; bus.resNumB = '0; bus.resMissB = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},  32'(bus.allocGrant),   0);
        chk({tag, "_num"},    32'(bus.allocNum),     0);
        chk({tag, "_tag"},    32'(bus.curBranchTag), 0);
        chk({tag, "_fen"},    32'(bus.bFreeEn),      0);
        chk({tag, "_fnum"},   32'(bus.bFreeNum),     0);
        chk({tag, "_flush"},  32'(bus.flushEn),      0);
        chk({tag, "_fmask"},  32'(bus.flushMask),    0);
        chk({tag, "_stall"},  32'(bus.stall),        0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive_idle();
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
    endtask

    // One cycle: drive inputs just after the edge, compare at the falling edge, advance the model.
    task automatic step(input bit req, input bit ea, input int na, input bit ma,
                        input bit eb, input int nb, input bit mb);
        bit       live [4];
        bit [3:0] busy_v;
        bit [3:0] kill;
        bit       stall_e, grant_e, va, vb;
        int       num_e, m, rel;

        bus.allocReq = req;
        bus.resEnA = ea; bus.resNumA = na[1:0]; bus.resMissA = ma;
        bus.resEnB = eb; bus.resNumB = nb[1:0]; bus.resMissB = mb;
        #4;

        busy_v = '0;
        num_e  = -1;
        for (int i = 0; i < 4; i++) begin
            busy_v[i] = m_busy[i];
            live[i]   = m_busy[i] && !m_dying[i];
            if (!m_busy[i] && num_e < 0) num_e = i;
        end
        stall_e = (stall_left > 0);
        grant_e = req && !stall_e && (num_e >= 0);

        chk("allocGrant",   32'(bus.allocGrant),   32'(grant_e));
        if (grant_e) chk("allocNum", 32'(bus.allocNum), 32'(num_e));
        chk("curBranchTag", 32'(bus.curBranchTag), 32'(busy_v));
        chk("bFreeEn",      32'(bus.bFreeEn),      32'(e_free_en));
        if (e_free_en) chk("bFreeNum", 32'(bus.bFreeNum), 32'(e_free_num));
        chk("flushEn",      32'(bus.flushEn),      32'(e_flush_en));
        if (e_flush_en) chk("flushMask", 32'(bus.flushMask), 32'(e_flush_mask));
        chk("stall",        32'(bus.stall),        32'(stall_e));

        // resolve qualification and oldest-mispredict selection by age
        va = ea && live[na];
        vb = eb && live[nb] && !(ea && na == nb);
        m  = -1;
        if (va && ma && vb && mb) m = (m_stamp[na] < m_stamp[nb]) ? na : nb;
        else if (va && ma)        m = na;
        else if (vb && mb)        m = nb;

        kill = '0;
        if (m >= 0) begin
            kill[m] = 1;
            for (int j = 0; j < 4; j++)
                if (live[j] && m_stamp[j] > m_stamp[m]) kill[j] = 1;
            if (grant_e) kill[num_e] = 1;
        end

        if (va && !ma && !kill[na]) m_pend[na] = 1;
        if (vb && !mb && !kill[nb]) m_pend[nb] = 1;
        for (int j = 0; j < 4; j++) if (kill[j]) m_pend[j] = 0;

        rel = -1;
        for (int j = 3; j >= 0; j--) if (m_pend[j]) rel = j;
        if (rel >= 0) m_pend[rel] = 0;

        for (int j = 0; j < 4; j++) if (m_dying[j]) m_busy[j] = 0;
        if (grant_e) begin
            m_busy[num_e]  = 1;
            m_stamp[num_e] = seq;
            seq++;
        end
        for (int j = 0; j < 4; j++) m_dying[j] = kill[j] || (rel == j);

        e_free_en    = (rel >= 0);
        e_free_num   = (rel >= 0) ? rel : 0;
        e_flush_en   = (m >= 0);
        e_flush_mask = kill;
        stall_left   = (m >= 0) ? 2 : ((stall_left > 0) ? stall_left - 1 : 0);

        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        bus.allocReq = 1;
        #1;
        chk_all_zero("reset");
        bus.allocReq = 0;
        rst = 1'b1;
        @(posedge clk); #1;

        // sequential allocation until full
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0, 0, 0);
        chk("seq_full_tag", 32'(bus.curBranchTag), 32'hf);

        // two correct resolves in one cycle drain one per cycle
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0, 0);
        chk("two_res_t1_en",  32'(bus.bFreeEn),  1);
        chk("two_res_t1_num", 32'(bus.bFreeNum), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("two_res_t2_num", 32'(bus.bFreeNum), 1);
        bus.allocReq = 1;
        #1;
        chk("two_res_reuse_grant", 32'(bus.allocGrant), 1);
        chk("two_res_reuse_num",   32'(bus.allocNum),   0);
        #0;
        step(1, 0, 0, 0, 0, 0, 0);

        // mispredict with dependents
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 0);
        chk("miss_mask",  32'(bus.flushMask), 32'h6);
        chk("miss_stall", 32'(bus.stall),     1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("miss_tag_t2", 32'(bus.curBranchTag), 32'h1);
        chk("miss_stall2", 32'(bus.stall),        1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("miss_stall_end", 32'(bus.stall), 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // dual mispredict: older slot 0 wins
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 2, 1, 1, 0, 1);
        chk("dual_mask", 32'(bus.flushMask), 32'h7);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("dual_single_pulse", 32'(bus.flushEn), 0);

        // correct resolve on a slot killed the same cycle
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0, 1);
        chk("killed_res_mask", 32'(bus.flushMask), 32'h3);
        chk("killed_res_free", 32'(bus.bFreeEn),   0);
        step(0, 0, 0, 0, 0, 0, 0);

        // reset while flushing with a release still pending
        do_reset();
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 1, 0);
        step(0, 1, 2, 0, 1, 3, 1);
        chk("midflush_flush", 32'(bus.flushEn), 1);
        rst = 1'b0;
        bus.allocReq = 1;
        #1;
        chk_all_zero("midflush_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        chk("midflush_first_tag", 32'(bus.curBranchTag), 32'h1);

        // random traffic against the model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_tag_ctrl.md
# branch_tag_ctrl

Branch-tag controller for the speculative back end. It hands out one-hot branch tags to the dispatcher and tracks which tags each new instruction depends on. It collects branch outcomes from two resolving units and serialises correct-prediction releases onto the single `bFreeEn`/`bFreeNum` broadcast consumed by the ROB and the reservation stations. On a misprediction it issues a kill mask and stalls dispatch for a fixed recovery window.

## Interface
- `BRANCH_NUM`, 4: number of branch tag slots; equals the width of `BranchTagBus`. Slot index width is 2.
- `FLUSH_CYCLES`, 2: dispatch-stall cycles after a flush pulse (≥1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `allocReq` in 1: dispatcher wants a tag for a branch this cycle.
- `allocGrant` out 1: combinational; request accepted this cycle.
- `allocNum` out 2: combinational; granted slot index, which is the lowest free slot.
- `curBranchTag` out BRANCH_NUM: registered mask of outstanding branches. Dispatched instructions copy it as their `BranchTag`.
- `resEnA`/`resNumA`/`resMissA` in 1/2/1: resolve port A (ALU), giving valid, slot, and mispredict flag.
- `resEnB`/`resNumB`/`resMissB` in 1/2/1: resolve port B (second branch unit), same meaning.
- `bFreeEn` out 1: registered; release of one correctly predicted branch.
- `bFreeNum` out 2: registered; the slot being released.
- `flushEn` out 1: registered one-cycle kill pulse.
- `flushMask` out BRANCH_NUM: registered; slots killed by that pulse.
- `stall` out 1: registered; dispatcher must not issue.

## Operation
- **Per-slot state:**
  - `busy[i]`: allocated and not yet released or killed.
  - `pend[i]`: resolved correct, release not yet broadcast.
  - `dep[i]`: snapshot of `busy` at allocation, i.e. the older branches.
- **Allocation:**
  - A slot is free when `busy[i]=0`.
  - `allocGrant = allocReq & rst & ~stall & any free slot`.
  - On grant, `busy[allocNum]` is set and `dep[allocNum]` takes the current `busy`.
  - `curBranchTag` equals `busy`, so it includes the new slot from the next cycle.
- **Resolve:**
  - A resolve whose slot has `busy=0`, or whose slot is killed in the same cycle, is ignored.
  - If A and B name the same slot, A wins and B is dropped.
- **Correct resolve:** sets `pend[i]`.
- **Release scheduler:**
  - Each cycle, the lowest-index set `pend` bit is broadcast: `bFreeEn=1`, `bFreeNum=i`.
  - In that cycle, `pend[i]` and `busy[i]` are cleared and bit i is cleared in every `dep[j]`.
  - One release per cycle. Surplus releases wait in `pend`.
- **Mispredict on slot m:**
  - Kill set K = {m} ∪ {j : busy[j] & dep[j][m]}.
  - `flushEn=1` and `flushMask=K` for one cycle.
  - `busy` and `pend` are cleared for all of K, and K's bits are cleared from every `dep`.
- **Both ports mispredict:** the older one is used. A is older iff `dep[B][A]`; otherwise B is used. The younger slot is always inside the older slot's kill set.
- **Mispredict plus correct resolve in the same cycle:** the correct resolve is honoured only if its slot is not in K.
- **Grant plus mispredict in the same cycle:** the grant still happens. The new slot depends on m, so it is in K.
- **Stall FSM:**
  - States: RUN and FLUSH, with counter `fc`.
  - RUN → FLUSH when `flushEn` is asserted, with `fc=FLUSH_CYCLES-1`.
  - FLUSH → RUN when `fc=0`, otherwise `fc` decrements.
  - A mispredict during FLUSH produces a new pulse and reloads `fc`.
- **Releases during FLUSH:** resolves and releases continue normally for surviving slots.
- **Reset (`rst=0`, asynchronous):**
  - `busy`, `pend`, and `dep` are cleared; FSM goes to RUN with `fc=0`.
  - `curBranchTag=0`, `bFreeEn=0`, `bFreeNum=0`, `flushEn=0`, `flushMask=0`, `stall=0`.
  - `allocGrant=0` and `allocNum=0` while reset is low.
  - Reset mid-flush or mid-release drops all pending work.

## Timing
- **Grant:** same cycle as `allocReq`. `curBranchTag` reflects the new slot one cycle later.
- **Correct resolve at cycle t:** `bFreeEn` no earlier than t+1, and later only by queued lower-index pends.
- **Mispredict at cycle t:** `flushEn`/`flushMask` at t+1. `stall` is high from t+1 through t+FLUSH_CYCLES inclusive.
- **Slot reuse:** a released or killed slot can be granted from the cycle after the release or flush pulse.
- **Full:** all 4 busy gives `allocGrant=0`. A grant becomes possible in the cycle after the first `bFreeEn` or `flushEn`.

## Test plan
- **Sequential allocation:** reset, then 4 consecutive `allocReq`. Expect grants of slots 0,1,2,3. `curBranchTag` goes 0001, 0011, 0111, 1111. A 5th request gets `allocGrant=0`.
- **Two correct resolves:** allocate slots 0,1, then resolve both correct in the same cycle (A=1, B=0). Expect `bFreeEn` with num 0 at t+1 and num 1 at t+2. Slot 0 is grantable at t+2.
- **Mispredict with dependents:** allocate slots 0,1,2, then A mispredicts slot 1. Expect at t+1 `flushEn=1` and `flushMask=0110`. `stall` is high for 2 cycles. `curBranchTag` becomes 0001 at t+2.
- **Dual mispredict:** with slots 0,1,2 allocated, A mispredicts slot 2 while B mispredicts slot 0. Expect a single pulse with `flushMask=0111`.
- **Correct resolve on a killed slot:** with slots 0,1 allocated, A correct on slot 1 while B mispredicts slot 0. Expect `flushMask=0011` and no `bFreeEn`.
- **Reset mid-flush:** deassert `rst` during FLUSH with `pend` set. All outputs go to 0 immediately. After reset release, the first grant is slot 0.
